// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a small input FIFO; framing (parity, stop bits, baud divider)
// is latched per frame when a word is popped, so mid-frame input changes have no effect.
module uart_tx_fifo_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          par_en,
  input  logic                          par_type,
  input  logic                          stop2,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  typedef struct packed {
    logic             par_en;
    logic             par_bit;
    logic             stop2;
    logic [DIV_W-1:0] div;
  } frame_cfg_t;

  // FIFO
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0] head;

  assign in_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM
  state_t                state, state_nxt;
  frame_cfg_t            cfg, cfg_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [DIV_W-1:0]      baud_cnt, baud_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic                  tick, load, tx_nxt;

  assign tick = (baud_cnt == '0);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg;
    shreg_nxt = shreg;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    load      = 1'b0;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    if (state == IDLE) begin
      load = !fifo_empty;
    end else if (!tick) begin
      baud_nxt = baud_cnt - DIV_W'(1);
    end else begin
      baud_nxt = cfg.div;
      case (state)
        START: begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
        DATA: begin
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            state_nxt = cfg.par_en ? PARITY : STOP1;
          end else begin
            bit_nxt   = bit_cnt + BW'(1);
            shreg_nxt = shreg >> 1;
          end
        end
        PARITY: state_nxt = STOP1;
        STOP1: begin
          if (cfg.stop2)        state_nxt = STOP2;
          else if (!fifo_empty) load      = 1'b1;
          else                  state_nxt = IDLE;
        end
        STOP2: begin
          if (!fifo_empty) load      = 1'b1;
          else             state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    // Pop latches the word and the whole frame configuration together
    if (load) begin
      pop             = 1'b1;
      state_nxt       = START;
      shreg_nxt       = head;
      baud_nxt        = baud_div;
      cfg_nxt.par_en  = par_en;
      cfg_nxt.par_bit = (^head) ^ par_type;
      cfg_nxt.stop2   = stop2;
      cfg_nxt.div     = baud_div;
    end
    // Line level is derived from the next state so tx_out changes on the same edge
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = cfg_nxt.par_bit;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cfg      <= '0;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_out   <= 1'b1;
    end else begin
      state    <= state_nxt;
      cfg      <= cfg_nxt;
      shreg    <= shreg_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx_out   <= tx_nxt;
    end
  end

endmodule
